// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states,
// digit-select encodings and the digit-count helper.
package booth_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Digit-select patterns packed as {zero, two, neg}; NEG is OR-ed onto PM1/PM2.
  localparam logic [2:0] ZERO = 3'b100;
  localparam logic [2:0] PM1  = 3'b000;
  localparam logic [2:0] PM2  = 3'b010;
  localparam logic [2:0] NEG  = 3'b001;

  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_seq_mult_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_radix4_seq_mult_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to {zero, two, neg}.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic       zero,
  output logic       two,
  output logic       neg
);

  logic [2:0] sel;

  always_comb begin
    sel = ZERO;
    unique case (window)
      3'b000, 3'b111: sel = ZERO;
      3'b001, 3'b010: sel = PM1;
      3'b011:         sel = PM2;
      3'b100:         sel = PM2 | NEG;
      3'b101, 3'b110: sel = PM1 | NEG;
      default:        sel = ZERO;
    endcase
  end

  assign {zero, two, neg} = sel;

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, signed or unsigned
// operands, start/busy/done handshake with a held result register.
module booth_radix4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  booth_radix4_seq_mult_if.slave bus
);

  localparam int DIGITS = booth_digits(WIDTH);
  localparam int EW     = WIDTH + 2;
  localparam int AW     = 2 * WIDTH + 4;
  localparam int CW     = $clog2(DIGITS);

  typedef logic [CW-1:0] count_t;
  localparam count_t LAST = count_t'(DIGITS - 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_radix4_seq_mult: WIDTH must be even and >= 4");
  end

  state_t             state, state_next;
  count_t             count;
  logic [EW:0]        mplr;
  logic [AW-1:0]      mcand;
  logic [AW-1:0]      acc;
  logic [2*WIDTH-1:0] result_q;
  logic               done_q;
  logic               accept, step, finish;
  logic               zero, two, neg;
  logic [EW-1:0]      ext_a, ext_b;
  logic [AW-1:0]      pp, addend, sum;

  assign ext_a = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign ext_b = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

  // Multiplier and multiplicand shift by one digit per step, so the window is
  // always mplr[2:0] and the partial product is already aligned to 2k.
  booth_r4_encoder u_encoder (
    .window (mplr[2:0]),
    .zero   (zero),
    .two    (two),
    .neg    (neg)
  );

  assign pp     = zero ? '0 : (two ? {mcand[AW-2:0], 1'b0} : mcand);
  assign addend = neg ? ~pp : pp;
  assign sum    = acc + addend + {{(AW-1){1'b0}}, neg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      mplr     <= '0;
      mcand    <= '0;
      acc      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        mplr  <= {ext_b, 1'b0};
        mcand <= {{(AW-EW){ext_a[EW-1]}}, ext_a};
        acc   <= '0;
        count <= '0;
      end else if (step) begin
        acc   <= sum;
        mplr  <= {2'b00, mplr[EW:2]};
        mcand <= {mcand[AW-3:0], 2'b00};
        count <= count + 1'b1;
        if (finish) result_q <= sum[2*WIDTH-1:0];
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench: four multiplier instances (WIDTH 4/8/16/32), directed
// corner cases plus randomized operations against an arithmetic reference.
module tb_booth_radix4_seq_mult;

  localparam int N_RAND = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_v [4];
  logic        sgn_v   [4];
  logic [31:0] a_v     [4];
  logic [31:0] b_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic [63:0] res_v   [4];
  int          done_cnt [4];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_w
    localparam int W = 4 << gi;
    booth_radix4_seq_mult_if #(.WIDTH(W)) bus ();
    booth_radix4_seq_mult #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign bus.start     = start_v[gi];
    assign bus.is_signed = sgn_v[gi];
    assign bus.a         = a_v[gi][W-1:0];
    assign bus.b         = b_v[gi][W-1:0];
    assign busy_v[gi]    = bus.busy;
    assign done_v[gi]    = bus.done;
    assign res_v[gi]     = 64'(bus.result);
  end

  // done is a single-cycle pulse, so one sample per negedge counts it once.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (done_v[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
  end

  function automatic int width_of(input int idx);
    return 4 << idx;
  endfunction

  // Reference: extend each operand to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_product(input int w, input logic s,
                                              input logic [31:0] x, input logic [31:0] y);
    logic [63:0] wmask, xe, ye, pmask;
    wmask = (64'd1 << w) - 64'd1;
    xe = 64'(x) & wmask;
    ye = 64'(y) & wmask;
    if (s && x[w-1]) xe = xe | ~wmask;
    if (s && y[w-1]) ye = ye | ~wmask;
    pmask = (64'd1 << (2 * w)) - 64'd1;
    return (xe * ye) & pmask;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int idx, input logic s, input logic [31:0] x, input logic [31:0] y);
    start_v[idx] = 1'b1;
    sgn_v[idx]   = s;
    a_v[idx]     = x;
    b_v[idx]     = y;
  endtask

  // Called at the negedge that is lat0 edges after the accept edge.
  task automatic wait_done(input int idx, input int lat0, output int lat);
    lat = lat0;
    while (done_v[idx] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int idx, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    int lat;
    @(negedge clk);
    drive_start(idx, s, x, y);
    @(negedge clk);
    start_v[idx] = 1'b0;
    wait_done(idx, 0, lat);
    check_output({tag, "_latency"}, 64'(lat), 64'(width_of(idx) / 2 + 1));
    check_output({tag, "_result"}, res_v[idx], ref_product(width_of(idx), s, x, y));
  endtask

  initial begin
    int lat, base, ops, pick;
    logic s;
    logic [31:0] x, y;

    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0; sgn_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; done_cnt[i] = 0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("reset_busy_w%0d", width_of(i)), 64'(busy_v[i]), 64'd0);
      check_output($sformatf("reset_done_w%0d", width_of(i)), 64'(done_v[i]), 64'd0);
      check_output($sformatf("reset_result_w%0d", width_of(i)), res_v[i], 64'd0);
    end
    reset = 1'b0;

    // WIDTH=8 corners
    run_op(1, 1'b1, 32'h80, 32'h80, "w8_minneg_sq");
    check_output("w8_minneg_sq_const", res_v[1], 64'h4000);
    run_op(1, 1'b0, 32'hFF, 32'hFF, "w8_u_ones");
    check_output("w8_u_ones_const", res_v[1], 64'hFE01);
    run_op(1, 1'b1, 32'hFF, 32'hFF, "w8_s_ones");
    check_output("w8_s_ones_const", res_v[1], 64'h0001);

    // WIDTH=32 corners
    run_op(3, 1'b1, 32'h7FFFFFFF, 32'h80000000, "w32_maxpos_minneg");
    check_output("w32_maxpos_minneg_const", res_v[3], 64'hC000000080000000);
    run_op(3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "w32_u_ones");
    check_output("w32_u_ones_const", res_v[3], 64'hFFFFFFFE00000001);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    drive_start(3, 1'b1, 32'h12345678, 32'hFEDCBA98);
    @(negedge clk);
    start_v[3] = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(3, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
    @(negedge clk);
    check_output("midrun_busy", 64'(busy_v[3]), 64'd1);
    start_v[3] = 1'b0;
    wait_done(3, 4, lat);
    check_output("midrun_latency", 64'(lat), 64'd17);
    check_output("midrun_result", res_v[3], ref_product(32, 1'b1, 32'h12345678, 32'hFEDCBA98));
    @(negedge clk);
    check_output("midrun_done_fall", 64'(done_v[3]), 64'd0);
    check_output("midrun_idle", 64'(busy_v[3]), 64'd0);

    // start held through done: back-to-back acceptance
    drive_start(3, 1'b1, 32'h80000000, 32'h00000003);
    @(negedge clk);
    a_v[3] = 32'h00010001; b_v[3] = 32'hFFFF0000; sgn_v[3] = 1'b0;
    wait_done(3, 0, lat);
    check_output("b2b_first_latency", 64'(lat), 64'd17);
    check_output("b2b_first_result", res_v[3], ref_product(32, 1'b1, 32'h80000000, 32'h00000003));
    @(negedge clk);
    check_output("b2b_done_fall", 64'(done_v[3]), 64'd0);
    check_output("b2b_second_busy", 64'(busy_v[3]), 64'd1);
    start_v[3] = 1'b0;
    wait_done(3, 0, lat);
    check_output("b2b_second_latency", 64'(lat), 64'd17);
    check_output("b2b_second_result", res_v[3], ref_product(32, 1'b0, 32'h00010001, 32'hFFFF0000));

    // asynchronous reset in the middle of RUN aborts without a done
    @(negedge clk);
    drive_start(3, 1'b1, 32'hCAFEF00D, 32'h13579BDF);
    @(negedge clk);
    start_v[3] = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_busy", 64'(busy_v[3]), 64'd0);
    check_output("abort_done", 64'(done_v[3]), 64'd0);
    check_output("abort_result", res_v[3], 64'd0);
    #1 reset = 1'b0;
    base = done_cnt[3];
    repeat (25) @(negedge clk);
    check_output("abort_no_done", 64'(done_cnt[3] - base), 64'd0);
    run_op(3, 1'b1, 32'hCAFEF00D, 32'h13579BDF, "after_abort");

    // randomized regression per width
    for (int idx = 0; idx < 4; idx++) begin
      base = done_cnt[idx];
      ops = 0;
      for (int n = 0; n < N_RAND; n++) begin
        s = 1'($urandom);
        pick = int'($urandom_range(0, 7));
        x = $urandom;
        y = $urandom;
        if (pick == 0) begin x = '1; y = '1; end
        else if (pick == 1) begin x = 32'd1 << (width_of(idx) - 1); y = x; end
        else if (pick == 2) y = '1;
        run_op(idx, s, x, y, $sformatf("rand_w%0d_n%0d", width_of(idx), n));
        ops++;
      end
      @(negedge clk);
      check_output($sformatf("rand_w%0d_done_count", width_of(idx)), 64'(done_cnt[idx] - base), 64'(ops));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
